// File: rtl/adc_capture.sv
// adc_capture: triggered serial-ADC conversion, tagged 24-bit FIFO storage,
// and show-ahead byte-stream readout (tag, sample MSB, sample LSB).
module adc_capture #(
    parameter int CONV_CYCLES = 40,
    parameter int SCLK_DIV    = 2,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flag_adc,
    input  logic [15:0]           theBeanConfig,
    input  logic                  adc_sdo,
    output logic                  adc_cnv,
    output logic                  adc_sclk,
    output logic [7:0]            dout,
    output logic                  dout_valid,
    input  logic                  dout_rd,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overrun,
    output logic                  trig_missed
);
    typedef enum logic [1:0] {IDLE, CONV, SHIFT, STORE} state_t;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                r_state, w_next;
    logic [15:0]           r_cnt, r_div, r_sample;
    logic [3:0]            r_bit;
    logic                  r_sclk, r_overrun, r_missed;
    logic [7:0]            r_tag;
    logic [23:0]           r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wp, r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic [1:0]            r_phase;
    logic                  w_conv_done, w_div_end, w_last, w_rd, w_pop, w_store, w_wr;
    logic [23:0]           w_head;
    logic                  w_unused;

    assign w_unused    = ^theBeanConfig[15:8];
    assign w_conv_done = r_cnt == 16'(CONV_CYCLES - 1);
    assign w_div_end   = r_div == 16'(SCLK_DIV - 1);
    assign w_last      = w_div_end && r_sclk && r_bit == 4'd15;
    assign w_store     = r_state == STORE;
    assign w_rd        = dout_rd && dout_valid;
    assign w_pop       = w_rd && r_phase == 2'd2;
    // A final-byte pop in the STORE cycle frees the slot the write needs.
    assign w_wr        = w_store && (r_count != FULL || w_pop);
    assign w_head      = r_mem[r_rp];

    assign busy        = r_state != IDLE;
    assign adc_cnv     = r_state == CONV;
    assign adc_sclk    = r_sclk;
    assign fifo_count  = r_count;
    assign dout_valid  = r_count != '0;
    assign overrun     = r_overrun;
    assign trig_missed = r_missed;
    assign dout        = !dout_valid ? 8'h00 :
                         r_phase == 2'd0 ? w_head[23:16] :
                         r_phase == 2'd1 ? w_head[15:8] : w_head[7:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = flag_adc ? CONV : IDLE;
            CONV:    w_next = w_conv_done ? SHIFT : CONV;
            SHIFT:   w_next = w_last ? STORE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_sclk    <= 1'b0;
            r_sample  <= '0;
            r_tag     <= '0;
            r_missed  <= 1'b0;
        end else begin
            if (r_state == IDLE && flag_adc) r_tag <= theBeanConfig[7:0];
            if (busy && flag_adc) r_missed <= 1'b1;
            r_cnt <= (r_state == CONV && !w_conv_done) ? r_cnt + 16'd1 : '0;
            if (r_state == SHIFT) begin
                r_div <= w_div_end ? '0 : r_div + 16'd1;
                // Data is captured on the edge that raises sclk.
                if (w_div_end) begin
                    r_sclk <= !r_sclk;
                    if (!r_sclk) r_sample <= {r_sample[14:0], adc_sdo};
                    else         r_bit    <= r_bit + 4'd1;
                end
            end else begin
                r_div  <= '0;
                r_sclk <= 1'b0;
                r_bit  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= {r_tag, r_sample};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_phase   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_wp    <= r_wp + DEPTH_LOG2'(w_wr);
            r_rp    <= r_rp + DEPTH_LOG2'(w_pop);
            r_count <= r_count + {{DEPTH_LOG2{1'b0}}, w_wr} - {{DEPTH_LOG2{1'b0}}, w_pop};
            r_phase <= w_rd ? (r_phase == 2'd2 ? 2'd0 : r_phase + 2'd1) : r_phase;
            if (w_store && !w_wr) r_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: randomized scoreboard bench with an ADC model and a
// countdown/queue reference model of the capture pipeline.
module tb_adc_capture;
    localparam int CONV  = 40;
    localparam int DIV   = 2;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int SHIFT = 32 * DIV;
    localparam int BUSY  = CONV + SHIFT + 1;

    logic         clk, rst, flag_adc, adc_sdo, dout_rd;
    logic [15:0]  theBeanConfig, stim_sample;
    logic         adc_cnv, adc_sclk, dout_valid, busy, overrun, trig_missed;
    logic [7:0]   dout;
    logic [DL2:0] fifo_count;

    int total = 0, bad = 0;

    int          m_busy = 0, m_phase = 0;
    logic [7:0]  m_tag = 0;
    logic [15:0] m_sample = 0;
    logic [23:0] m_words[$];
    logic [7:0]  exp_bytes[$];
    bit          m_over = 0, m_miss = 0, rd_ok, st;

    logic [15:0] sr = 0;
    logic        p_cnv = 0, p_sclk = 0;

    adc_capture #(.CONV_CYCLES(CONV), .SCLK_DIV(DIV), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .flag_adc(flag_adc), .theBeanConfig(theBeanConfig),
        .adc_sdo(adc_sdo), .adc_cnv(adc_cnv), .adc_sclk(adc_sclk), .dout(dout),
        .dout_valid(dout_valid), .dout_rd(dout_rd), .busy(busy),
        .fifo_count(fifo_count), .overrun(overrun), .trig_missed(trig_missed)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a busy countdown per accepted trigger and a word queue.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_phase = 0; m_over = 0; m_miss = 0;
            m_words.delete();
            exp_bytes.delete();
        end else begin
            rd_ok = dout_rd && m_words.size() != 0;
            st    = m_busy == 1;
            if (rd_ok && m_phase == 2) void'(m_words.pop_front());
            if (st) begin
                if (m_words.size() < DEPTH) begin
                    m_words.push_back({m_tag, m_sample});
                    exp_bytes.push_back(m_tag);
                    exp_bytes.push_back(m_sample[15:8]);
                    exp_bytes.push_back(m_sample[7:0]);
                end else m_over = 1;
            end
            if (rd_ok) m_phase = (m_phase + 1) % 3;
            if (flag_adc && m_busy != 0) m_miss = 1;
            if (flag_adc && m_busy == 0) begin
                m_busy   = BUSY;
                m_tag    = theBeanConfig[7:0];
                m_sample = stim_sample;
            end else if (m_busy > 0) m_busy--;
        end
    end

    // ADC model: loads at conversion end, presents MSB, shifts on sclk fall.
    always @(negedge clk) begin
        if (p_cnv && !adc_cnv) sr = m_sample;
        else if (p_sclk && !adc_sclk) sr = sr << 1;
        adc_sdo = sr[15];
        p_cnv   = adc_cnv;
        p_sclk  = adc_sclk;
    end

    // Monitor: per-cycle status against the model, bytes against the scoreboard.
    always @(negedge clk) begin
        int k;
        k = SHIFT + 1 - m_busy;
        chk("busy", busy, m_busy != 0);
        chk("adc_cnv", adc_cnv, m_busy > SHIFT + 1);
        chk("adc_sclk", adc_sclk, m_busy >= 2 && m_busy <= SHIFT + 1 && ((k / DIV) % 2 == 1));
        chk("fifo_count", fifo_count, m_words.size());
        chk("dout_valid", dout_valid, m_words.size() != 0);
        chk("overrun", overrun, m_over);
        chk("trig_missed", trig_missed, m_miss);
        if (dout_valid && exp_bytes.size() != 0) begin
            chk("dout", dout, exp_bytes[0]);
            if (dout_rd) void'(exp_bytes.pop_front());
        end else if (!dout_valid) chk("dout_idle", dout, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input logic [15:0] cfg, input logic [15:0] smp);
        theBeanConfig = cfg;
        stim_sample   = smp;
        flag_adc      = 1;
        tick();
        flag_adc      = 0;
    endtask

    task automatic reset_dut();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic drain(input int n);
        dout_rd = 1;
        repeat (n) tick();
        dout_rd = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; flag_adc = 0; dout_rd = 0; theBeanConfig = 0; stim_sample = 0;
        tick();
        tick();
        rst = 0;
        repeat (20) tick();

        conv(16'h12A5, 16'hBEEF);
        repeat (48) tick();
        conv(16'h0033, 16'h1234);
        repeat (60) tick();
        drain(3);
        repeat (5) tick();

        reset_dut();
        for (int i = 0; i < 17; i++) begin
            conv(16'($urandom), 16'($urandom));
            repeat (BUSY) tick();
        end
        drain(3 * DEPTH + 4);

        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            conv(16'($urandom), 16'($urandom));
            repeat (BUSY) tick();
        end
        conv(16'h00C3, 16'h5A5A);
        repeat (BUSY - 3) tick();
        drain(3);
        repeat (4) tick();
        drain(3 * DEPTH + 4);

        reset_dut();
        conv(16'h0077, 16'hFFFF);
        repeat (CONV + 8 * 2 * DIV + 1) tick();
        reset_dut();
        repeat (3) tick();
        conv(16'h0081, 16'h0F0F);
        repeat (BUSY + 2) tick();
        drain(4);

        for (int i = 0; i < 4000; i++) begin
            flag_adc      = $urandom_range(0, 99) < 2;
            dout_rd       = $urandom_range(0, 99) < 30;
            theBeanConfig = 16'($urandom);
            stim_sample   = 16'($urandom);
            tick();
        end
        flag_adc = 0;
        dout_rd  = 0;
        repeat (BUSY + 5) tick();
        drain(3 * DEPTH + 4);
        repeat (2) tick();
        chk("scoreboard_leftover", exp_bytes.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
